// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the default frame
// settings that the transmitter and receiver agree on.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK
    } rx_state_t;

    localparam int UART_DIV_DEFAULT = 16;
    localparam int UART_DATA_BITS   = 8;

endpackage

// File: rtl/uart_sync2.sv
// Generic two-flop synchroniser for an asynchronous single-bit input.
// RST_VAL selects the value both flops take on reset, so an idle-high line
// does not look like an active edge as reset is released.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage shift toward the clk domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronises rx, finds the start bit, samples each bit at
// mid-period, assembles LSB-first data and presents it on a valid/ready
// output register. Framing errors and overruns are single-cycle pulses.
// Optional even-parity checking is built when UART_RX_PARITY_EN is defined.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DIV       = UART_DIV_DEFAULT,
    parameter int DATA_BITS = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam int DIV_W = $clog2(DIV);
    localparam int CNT_W = $clog2(DATA_BITS + 1);
    localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(DIV / 2 - 1);
    localparam logic [DIV_W-1:0] BIT_LAST  = DIV_W'(DIV - 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS - 1);

    logic                 w_rx_s;
    rx_state_t            r_state;
    rx_state_t            w_state_next;
    logic [DIV_W-1:0]     r_div;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_rx_valid;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_frame_err;
    logic                 r_overrun;

    logic w_half;
    logic w_full;
    logic w_div_clear;
    logic w_shift_en;
    logic w_offer;
    logic w_stop_bad;
`ifdef UART_RX_PARITY_EN
    logic w_par_chk;
    logic r_parity_err;
`endif

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (rx),
        .o_q (w_rx_s)
    );

    assign w_half = (r_div == HALF_LAST);
    assign w_full = (r_div == BIT_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        w_state_next = r_state;
        w_div_clear  = 1'b0;
        w_shift_en   = 1'b0;
        w_offer      = 1'b0;
        w_stop_bad   = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_chk    = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                w_div_clear = 1'b1;
                if (!w_rx_s) begin
                    w_state_next = START;
                end
            end
            START: begin
                if (w_half) begin
                    w_div_clear  = 1'b1;
                    // A high mid-bit sample means the low was only a glitch.
                    w_state_next = w_rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (w_full) begin
                    w_div_clear = 1'b1;
                    w_shift_en  = 1'b1;
                    if (r_bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        w_state_next = PARITY;
`else
                        w_state_next = STOP;
`endif
                    end
                end
            end
            PARITY: begin
                if (w_full) begin
                    w_div_clear  = 1'b1;
`ifdef UART_RX_PARITY_EN
                    w_par_chk    = 1'b1;
`endif
                    w_state_next = STOP;
                end
            end
            STOP: begin
                if (w_full) begin
                    w_div_clear = 1'b1;
                    if (w_rx_s) begin
                        w_offer      = 1'b1;
                        w_state_next = IDLE;
                    end else begin
                        w_stop_bad   = 1'b1;
                        w_state_next = BRK;
                    end
                end
            end
            BRK: begin
                // Hold here until the line returns high so a long break
                // produces a single framing error.
                w_div_clear = 1'b1;
                if (w_rx_s) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_div_clear  = 1'b1;
                w_state_next = IDLE;
            end
        endcase
    end

    // Divider, bit counter and shift register; counters reload on every
    // state change so they never need to wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div     <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else begin
            r_div <= w_div_clear ? '0 : r_div + DIV_W'(1);
            if (w_state_next != r_state) begin
                r_bit_cnt <= '0;
            end else if (w_shift_en) begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
            if (w_shift_en) begin
                r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            end
        end
    end

    // Output register with valid/ready handshake and error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_stop_bad;
            r_overrun   <= 1'b0;
            if (w_offer) begin
                if (!r_rx_valid || rx_ready) begin
                    r_rx_data  <= r_shift;
                    r_rx_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even parity: data bits XOR parity bit must be zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= w_par_chk & ((^r_shift) ^ w_rx_s);
        end
    end

    assign parity_err = r_parity_err;
`endif

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: directed scenarios plus random frames checked
// against a queue-based model of the delivered byte stream.
// Builds with or without UART_RX_PARITY_EN.
module tb_uart_rx;

    localparam int DIV = 16;
    localparam int NB  = 8;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int LATENCY = DIV / 2 + NB * DIV + DIV + PAR_BITS * DIV + 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx = 1'b1;
    logic          rx_ready = 1'b0;
    logic [NB-1:0] rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic          overrun;
    logic          busy;
`ifdef UART_RX_PARITY_EN
    logic          parity_err;
`endif

    always #5 clk = ~clk;

    uart_rx #(.DIV(DIV), .DATA_BITS(NB)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int last_rise = -1;
    int n_valid_hi = 0;
    int n_ferr = 0;
    int n_ovr = 0;
    int n_perr = 0;
    logic prev_valid = 1'b0;
    logic [NB-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: pulse counters and handshake scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            logic [NB-1:0] e;
            if (rx_valid && !prev_valid) last_rise = cyc;
            prev_valid = rx_valid;
            n_valid_hi += int'(rx_valid);
            n_ferr     += int'(frame_err);
            n_ovr      += int'(overrun);
`ifdef UART_RX_PARITY_EN
            n_perr     += int'(parity_err);
`endif
            if (rx_valid && rx_ready) begin
                check("q_nonempty", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("rx_data", 32'(rx_data), 32'(e));
                    $display("byte 0x%02h accepted at cycle %0d", rx_data, cyc);
                end
            end
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        tick(DIV);
    endtask

    task automatic send_frame(input logic [NB-1:0] d, input logic stop_b, input logic par_flip);
        start_cyc = cyc;
        send_bit(1'b0);
        for (int i = 0; i < NB; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ par_flip);
`endif
        send_bit(stop_b);
        $display("frame 0x%02h sent stop=%0b par_flip=%0b", d, stop_b, par_flip);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) break;
            tick(1);
        end
        check("q_drain", 32'(exp_q.size()), 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int v0, f0, o0, p0;
        logic [NB-1:0] d;

        // Reset state
        rst = 1'b1;
        tick(3);
        check("rst_valid", 32'(rx_valid), 0);
        check("rst_data", 32'(rx_data), 0);
        check("rst_ferr", 32'(frame_err), 0);
        check("rst_ovr", 32'(overrun), 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        tick(2);

        // Test 1: single good frame, latency
        rx_ready = 1'b1;
        v0 = n_valid_hi; f0 = n_ferr; o0 = n_ovr;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0);
        check("t1_latency", 32'(last_rise - start_cyc), 32'(LATENCY));
        check("t1_valid_cycles", 32'(n_valid_hi - v0), 1);
        check("t1_ferr", 32'(n_ferr - f0), 0);
        check("t1_ovr", 32'(n_ovr - o0), 0);
        wait_drain();
        tick(DIV);

        // Test 2: start glitch
        v0 = n_valid_hi; f0 = n_ferr;
        rx = 1'b0;
        tick(4);
        check("t2_busy_glitch", 32'(busy), 1);
        rx = 1'b1;
        tick(DIV / 2 + 3 - 4);
        check("t2_busy_idle", 32'(busy), 0);
        tick(DIV);
        check("t2_valid", 32'(n_valid_hi - v0), 0);
        check("t2_ferr", 32'(n_ferr - f0), 0);

        // Test 3: bad stop bit followed by a long break
        v0 = n_valid_hi; f0 = n_ferr;
        send_frame(8'h3C, 1'b0, 1'b0);
        rx = 1'b0;
        tick(40 * DIV);
        rx = 1'b1;
        tick(2 * DIV);
        check("t3_ferr_once", 32'(n_ferr - f0), 1);
        check("t3_no_valid", 32'(n_valid_hi - v0), 0);
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, 1'b0);
        wait_drain();
        check("t3_data_after", 32'(rx_data), 32'h55);
        tick(DIV);

        // Test 4: back-to-back frames with downstream stalled
        rx_ready = 1'b0;
        o0 = n_ovr;
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b1, 1'b0);
        send_frame(8'h34, 1'b1, 1'b0);
        check("t4_ovr_once", 32'(n_ovr - o0), 1);
        check("t4_valid_held", 32'(rx_valid), 1);
        check("t4_data_held", 32'(rx_data), 32'h12);
        check("t4_q_pending", 32'(exp_q.size()), 1);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        check("t4_valid_clear", 32'(rx_valid), 0);
        check("t4_q_empty", 32'(exp_q.size()), 0);
        tick(DIV);

        // Test 5: reset mid-frame discards pending byte and frame
        send_frame(8'h5A, 1'b1, 1'b0);
        check("t5_pending", 32'(rx_valid), 1);
        rx = 1'b0;
        tick(DIV);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        rx = 1'b1;
        tick(DIV / 2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("t5_valid", 32'(rx_valid), 0);
        check("t5_data", 32'(rx_data), 0);
        check("t5_ferr", 32'(frame_err), 0);
        check("t5_ovr", 32'(overrun), 0);
        check("t5_busy", 32'(busy), 0);
        tick(DIV / 2 + 4 * DIV + 2 * DIV);
        rx_ready = 1'b1;
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, 1'b0);
        wait_drain();
        check("t5_data_after", 32'(rx_data), 32'h81);
        tick(DIV);

        // Random frames with random idle gaps, downstream always ready
        f0 = n_ferr; o0 = n_ovr; v0 = n_valid_hi;
        for (int k = 0; k < 25; k++) begin
            d = NB'($urandom);
            exp_q.push_back(d);
            send_frame(d, 1'b1, 1'b0);
            tick($urandom_range(0, 3));
        end
        wait_drain();
        check("rand_count", 32'(n_valid_hi - v0), 25);
        check("rand_ferr", 32'(n_ferr - f0), 0);
        check("rand_ovr", 32'(n_ovr - o0), 0);

`ifdef UART_RX_PARITY_EN
        // Test 6: parity good then bad
        tick(DIV);
        p0 = n_perr;
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b0);
        wait_drain();
        check("t6_perr_good", 32'(n_perr - p0), 0);
        check("t6_data_good", 32'(rx_data), 32'h07);
        p0 = n_perr;
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b1);
        wait_drain();
        check("t6_perr_bad", 32'(n_perr - p0), 1);
        check("t6_data_bad", 32'(rx_data), 32'h07);
`else
        p0 = n_perr;
        check("perr_none", 32'(p0), 0);
`endif

        tick(4);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
